// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared types and constants for the clock monitor.
//   state_t    - monitor FSM states (IDLE, MEASURE, STALLED)
//   SYNC_DEPTH - number of synchronizer flops in front of edge detection
package clock_monitor_pkg;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

endpackage

// File: rtl/clock_monitor_if.sv
// clock_monitor_if: measured clock input plus measurement results.
//   clock_in      - slow clock to be measured (asynchronous)
//   rise_pulse    - one-cycle strobe per detected clock_in rising edge
//   fall_pulse    - one-cycle strobe per detected clock_in falling edge
//   period        - last measured period in system clock cycles
//   high_time     - last measured high time in system clock cycles
//   measure_valid - one-cycle strobe when period updates
//   stalled       - level, clock_in considered stopped
// master = the monitor, slave = the consumer / clock_in driver.
interface clock_monitor_if #(
  parameter int unsigned CNT_WIDTH = 32
);

  logic                 clock_in;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] high_time;
  logic                 measure_valid;
  logic                 stalled;

  modport master (
    input  clock_in,
    output rise_pulse, fall_pulse, period, high_time, measure_valid, stalled
  );

  modport slave (
    output clock_in,
    input  rise_pulse, fall_pulse, period, high_time, measure_valid, stalled
  );

endinterface

// File: rtl/clock_monitor_sync_edge_detect.sv
// sync_edge_detect: synchronizes an asynchronous input into the clock domain
// and emits registered one-cycle strobes on its rising and falling edges.
//   clock    - system clock
//   reset    - synchronous, active-high reset
//   async_in - asynchronous input
//   rise     - strobe on detected rising edge
//   fall     - strobe on detected falling edge
module sync_edge_detect
  import clock_monitor_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  hist_q;

  // Synchronizer chain, history flop and registered edge strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
      hist_q <= sync_q[SYNC_DEPTH-1];
      rise   <= sync_q[SYNC_DEPTH-1] & ~hist_q;
      fall   <= ~sync_q[SYNC_DEPTH-1] & hist_q;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures the period (and optionally high time) of a slow,
// asynchronous clock in system clock cycles and flags it as stalled when no
// rising edge arrives within TIMEOUT cycles.
//   clock - system clock (rising edge)
//   reset - synchronous, active-high reset
//   mon   - clock_monitor_if.master: clock_in in, measurement results out
// Parameters: CNT_WIDTH (counter/output width), TIMEOUT (stall threshold).
// Optional feature: define CLOCK_MONITOR_DUTY_EN to build high-time
// measurement; otherwise high_time is tied to zero.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  clock_monitor_if.master   mon
);

  localparam int unsigned CMP_W = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 rise;
  logic                 fall;
  state_t               state;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] period_q;
  logic                 valid_q;
  logic                 stalled_q;
  logic [CNT_WIDTH-1:0] count_inc_c;
  logic                 timeout_c;

  sync_edge_detect u_sync_edge_detect (
    .clock    (clock),
    .reset    (reset),
    .async_in (mon.clock_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Saturating increment and timeout compare, widened so TIMEOUT never truncates.
  assign count_inc_c = (count == CNT_MAX) ? count : count + CNT_ONE;
  assign timeout_c   = (CMP_W'(count) >= CMP_W'(TIMEOUT));

  // Monitor FSM: rise_pulse takes priority over timeout in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            count <= CNT_ONE;
            state <= MEASURE;
          end else if (timeout_c) begin
            state     <= STALLED;
            stalled_q <= 1'b1;
          end else begin
            count <= count_inc_c;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_q <= count;
            valid_q  <= 1'b1;
            count    <= CNT_ONE;
          end else if (timeout_c) begin
            state     <= STALLED;
            stalled_q <= 1'b1;
          end else begin
            count <= count_inc_c;
          end
        end
        STALLED: begin
          if (rise) begin
            count     <= CNT_ONE;
            state     <= MEASURE;
            stalled_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_WIDTH-1:0] high_q;

  // Count since the last rise is the high time when the fall arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_q <= '0;
    end else if (state == MEASURE && fall) begin
      high_q <= count;
    end
  end

  assign mon.high_time = high_q;
`else
  assign mon.high_time = '0;
`endif

  assign mon.rise_pulse    = rise;
  assign mon.fall_pulse    = fall;
  assign mon.period        = period_q;
  assign mon.measure_valid = valid_q;
  assign mon.stalled       = stalled_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed self-checking bench for clock_monitor.
// Instance a: CNT_WIDTH=32, TIMEOUT=100. Instance b: CNT_WIDTH=4, TIMEOUT=1000.
// Both share clock/reset and see the same clock_in waveform.
module tb_clock_monitor;

  localparam int unsigned W_A  = 32;
  localparam int unsigned TO_A = 100;
  localparam int unsigned W_B  = 4;
  localparam int unsigned TO_B = 1000;

`ifdef CLOCK_MONITOR_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  clock_monitor_if #(.CNT_WIDTH(W_A)) if_a ();
  clock_monitor_if #(.CNT_WIDTH(W_B)) if_b ();

  clock_monitor #(.CNT_WIDTH(W_A), .TIMEOUT(TO_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .mon   (if_a.master)
  );

  clock_monitor #(.CNT_WIDTH(W_B), .TIMEOUT(TO_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .mon   (if_b.master)
  );

  int checks = 0;
  int errors = 0;

  int          cyc_num;
  int          va_cnt;
  logic [31:0] va_period;
  logic [31:0] va_high;
  int          vb_cnt;
  logic [3:0]  vb_period;
  logic [3:0]  vb_high;
  int          stall_cnt;
  int          last_rise_cyc;
  int          first_stall_cyc;
  int          dbl_valid = 0;
  logic        mv_prev = 1'b0;

  task automatic clear_obs();
    cyc_num         = 0;
    va_cnt          = 0;
    va_period       = '0;
    va_high         = '0;
    vb_cnt          = 0;
    vb_period       = '0;
    vb_high         = '0;
    stall_cnt       = 0;
    last_rise_cyc   = -1;
    first_stall_cyc = -1;
  endtask

  // One system clock cycle: drive clock_in at negedge, observe 1 after posedge.
  task automatic cyc(input logic v);
    @(negedge clock);
    if_a.clock_in = v;
    if_b.clock_in = v;
    @(posedge clock);
    #1;
    cyc_num++;
    if (if_a.rise_pulse) last_rise_cyc = cyc_num;
    if (if_a.stalled) begin
      if (first_stall_cyc < 0) first_stall_cyc = cyc_num;
      stall_cnt++;
    end
    if (if_a.measure_valid) begin
      if (mv_prev) dbl_valid++;
      va_cnt++;
      va_period = if_a.period;
      va_high   = if_a.high_time;
    end
    mv_prev = if_a.measure_valid;
    if (if_b.measure_valid) begin
      vb_cnt++;
      vb_period = if_b.period;
      vb_high   = if_b.high_time;
    end
  endtask

  task automatic run(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cyc(1'b0);
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    clear_obs();
    if_a.clock_in = 1'b0;
    if_b.clock_in = 1'b0;
    repeat (3) cyc(1'b0);
    checks++; if (if_a.rise_pulse !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b expected 0", if_a.rise_pulse); end
    checks++; if (if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL reset_fall: got %b expected 0", if_a.fall_pulse); end
    checks++; if (if_a.period !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", if_a.period); end
    checks++; if (if_a.high_time !== 32'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", if_a.high_time); end
    checks++; if (if_a.measure_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_a.measure_valid); end
    checks++; if (if_a.stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %b expected 0", if_a.stalled); end
    checks++; if (if_b.period !== 4'd0) begin errors++; $display("FAIL reset_period_b: got %0d expected 0", if_b.period); end
  endtask

  task automatic test_latency();
    reset = 1'b0;
    clear_obs();
    cyc(1'b1);
    cyc(1'b1);
    checks++; if (if_a.rise_pulse !== 1'b0) begin errors++; $display("FAIL lat_rise_early: got %b expected 0", if_a.rise_pulse); end
    cyc(1'b1);
    checks++; if (if_a.rise_pulse !== 1'b1) begin errors++; $display("FAIL lat_rise_edge3: got %b expected 1", if_a.rise_pulse); end
    cyc(1'b1);
    checks++; if (if_a.rise_pulse !== 1'b0) begin errors++; $display("FAIL lat_rise_width: got %b expected 0", if_a.rise_pulse); end
    checks++; if (if_a.measure_valid !== 1'b0) begin errors++; $display("FAIL lat_first_valid: got %b expected 0", if_a.measure_valid); end
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    checks++; if (if_a.fall_pulse !== 1'b1) begin errors++; $display("FAIL lat_fall_edge3: got %b expected 1", if_a.fall_pulse); end
    cyc(1'b0);
    checks++; if (if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL lat_fall_width: got %b expected 0", if_a.fall_pulse); end
  endtask

  task automatic test_toggle4();
    do_reset();
    run(4, 4, 6);
    checks++; if (va_cnt != 5) begin errors++; $display("FAIL t4_valid_cnt: got %0d expected 5", va_cnt); end
    checks++; if (va_period !== 32'd8) begin errors++; $display("FAIL t4_period: got %0d expected 8", va_period); end
    checks++; if (va_high !== (DUTY ? 32'd4 : 32'd0)) begin errors++; $display("FAIL t4_high: got %0d expected %0d", va_high, DUTY ? 4 : 0); end
  endtask

  task automatic test_duty_3_7();
    do_reset();
    run(3, 7, 5);
    checks++; if (va_cnt != 4) begin errors++; $display("FAIL d37_valid_cnt: got %0d expected 4", va_cnt); end
    checks++; if (va_period !== 32'd10) begin errors++; $display("FAIL d37_period: got %0d expected 10", va_period); end
    checks++; if (va_high !== (DUTY ? 32'd3 : 32'd0)) begin errors++; $display("FAIL d37_high: got %0d expected %0d", va_high, DUTY ? 3 : 0); end
  endtask

  task automatic test_stall();
    do_reset();
    run(4, 4, 3);
    checks++; if (va_cnt != 2) begin errors++; $display("FAIL st_pre_cnt: got %0d expected 2", va_cnt); end
    run(0, 110, 1);
    checks++; if (first_stall_cyc < 0) begin errors++; $display("FAIL st_not_stalled: got none expected stall"); end
    checks++; if (first_stall_cyc - last_rise_cyc > 101) begin errors++; $display("FAIL st_latency: got %0d expected <=101", first_stall_cyc - last_rise_cyc); end
    checks++; if (if_a.stalled !== 1'b1) begin errors++; $display("FAIL st_level: got %b expected 1", if_a.stalled); end
    checks++; if (va_cnt != 2) begin errors++; $display("FAIL st_no_valid: got %0d expected 2", va_cnt); end
    checks++; if (if_a.period !== 32'd8) begin errors++; $display("FAIL st_period_hold: got %0d expected 8", if_a.period); end
    checks++; if (if_a.high_time !== (DUTY ? 32'd4 : 32'd0)) begin errors++; $display("FAIL st_high_hold: got %0d expected %0d", if_a.high_time, DUTY ? 4 : 0); end
    run(5, 5, 1);
    checks++; if (if_a.stalled !== 1'b0) begin errors++; $display("FAIL st_clear: got %b expected 0", if_a.stalled); end
    checks++; if (va_cnt != 2) begin errors++; $display("FAIL st_recover_no_valid: got %0d expected 2", va_cnt); end
    run(5, 5, 1);
    checks++; if (va_cnt != 3) begin errors++; $display("FAIL st_recover_valid: got %0d expected 3", va_cnt); end
    checks++; if (va_period !== 32'd10) begin errors++; $display("FAIL st_recover_period: got %0d expected 10", va_period); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(4, 4, 2);
    checks++; if (va_cnt != 1) begin errors++; $display("FAIL rm_pre_cnt: got %0d expected 1", va_cnt); end
    repeat (8) cyc(1'b1);
    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    checks++; if (if_a.period !== 32'd0) begin errors++; $display("FAIL rm_period: got %0d expected 0", if_a.period); end
    checks++; if (if_a.high_time !== 32'd0) begin errors++; $display("FAIL rm_high: got %0d expected 0", if_a.high_time); end
    checks++; if ({if_a.rise_pulse, if_a.fall_pulse, if_a.measure_valid, if_a.stalled} !== 4'b0000) begin
      errors++; $display("FAIL rm_flags: got %b expected 0000", {if_a.rise_pulse, if_a.fall_pulse, if_a.measure_valid, if_a.stalled});
    end
    reset = 1'b0;
    clear_obs();
    run(4, 4, 1);
    checks++; if (va_cnt != 0) begin errors++; $display("FAIL rm_first_rise: got %0d expected 0", va_cnt); end
    run(4, 4, 1);
    checks++; if (va_cnt != 1) begin errors++; $display("FAIL rm_second_rise: got %0d expected 1", va_cnt); end
    checks++; if (va_period !== 32'd8) begin errors++; $display("FAIL rm_period_after: got %0d expected 8", va_period); end
  endtask

  task automatic test_coincide();
    do_reset();
    run(50, 50, 3);
    checks++; if (va_cnt != 2) begin errors++; $display("FAIL co_valid_cnt: got %0d expected 2", va_cnt); end
    checks++; if (va_period !== 32'd100) begin errors++; $display("FAIL co_period: got %0d expected 100", va_period); end
    checks++; if (stall_cnt != 0) begin errors++; $display("FAIL co_stalled: got %0d stalled cycles expected 0", stall_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    run(20, 20, 3);
    checks++; if (vb_cnt != 2) begin errors++; $display("FAIL sat_valid_cnt: got %0d expected 2", vb_cnt); end
    checks++; if (vb_period !== 4'd15) begin errors++; $display("FAIL sat_period: got %0d expected 15", vb_period); end
    checks++; if (vb_high !== (DUTY ? 4'd15 : 4'd0)) begin errors++; $display("FAIL sat_high: got %0d expected %0d", vb_high, DUTY ? 15 : 0); end
    checks++; if (if_b.stalled !== 1'b0) begin errors++; $display("FAIL sat_stalled: got %b expected 0", if_b.stalled); end
  endtask

  initial begin
    if_a.clock_in = 1'b0;
    if_b.clock_in = 1'b0;
    test_reset();
    test_latency();
    test_toggle4();
    test_duty_3_7();
    test_stall();
    test_reset_mid();
    test_coincide();
    test_saturate();
    checks++; if (dbl_valid != 0) begin errors++; $display("FAIL valid_width: got %0d back-to-back valids expected 0", dbl_valid); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32, which sets the width of the period and high-time counters and outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 50000000, the number of clock cycles without a clock_in rising edge before stall is declared.
REQ-003 The block SHALL have port clock, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port clock_in, input, 1 bit: slow clock to be measured, asynchronous to clock.
REQ-006 The block SHALL have port rise_pulse, output, 1 bit: one-cycle strobe on each detected clock_in rising edge.
REQ-007 The block SHALL have port fall_pulse, output, 1 bit: one-cycle strobe on each detected clock_in falling edge.
REQ-008 The block SHALL have port period, output, CNT_WIDTH bits: last measured clock_in period, in clock cycles.
REQ-009 The block SHALL have port high_time, output, CNT_WIDTH bits: last measured clock_in high time, in clock cycles.
REQ-010 The block SHALL have port measure_valid, output, 1 bit: one-cycle strobe when period is updated.
REQ-011 The block SHALL have port stalled, output, 1 bit: level, high while clock_in is considered stopped.

Function
REQ-012 clock_in SHALL pass through a 2-flop synchronizer followed by a history flop; rise_pulse = sync2 & ~hist, fall_pulse = ~sync2 & hist.
REQ-013 rise_pulse SHALL assert exactly 3 clock edges after the first edge that samples clock_in high, for exactly 1 cycle.
REQ-014 The FSM SHALL have states IDLE, MEASURE and STALLED; reset enters IDLE.
REQ-015 In IDLE, the first rise_pulse SHALL load count=1 and move to MEASURE; measure_valid stays low on this edge.
REQ-016 In MEASURE, count SHALL increment by 1 every cycle and saturate at 2^CNT_WIDTH-1, with no wrap.
REQ-017 On rise_pulse in MEASURE, the block SHALL load period with count, pulse measure_valid for 1 cycle (the cycle after the edge), and reload count=1. A clock_in with a steady period of P cycles SHALL yield period==P.
REQ-018 In MEASURE or IDLE, when count (or idle cycles) reaches TIMEOUT without a rise_pulse, the block SHALL move to STALLED and assert stalled the next cycle.
REQ-019 In STALLED, the period and high_time values SHALL be held, and no measure_valid pulses SHALL be generated.
REQ-020 On rise_pulse in STALLED, the block SHALL set count=1, enter MEASURE and deassert stalled; no measure_valid is generated on that edge.
REQ-021 When a rise_pulse and a timeout occur in the same cycle, rise_pulse SHALL win.
REQ-022 A fall_pulse outside MEASURE SHALL be ignored for measurement, but fall_pulse SHALL still be output.

Reset
REQ-023 While reset is asserted, the block SHALL hold: state=IDLE, sync/history flops=0, count=0, period=0, high_time=0, rise_pulse=0, fall_pulse=0, measure_valid=0, stalled=0.
REQ-024 Reset asserted mid-measurement SHALL discard the partial count, with no measure_valid generated.
REQ-025 The first measure_valid after reset SHALL require two clock_in rising edges.

Configuration
REQ-026 With macro CLOCK_MONITOR_DUTY_EN defined, the block SHALL load high_time with count on each fall_pulse in MEASURE.
REQ-027 With CLOCK_MONITOR_DUTY_EN undefined, high_time SHALL be tied to 0 and no high-time logic SHALL be built; the port list is unchanged.

Structure
REQ-028 Package clock_monitor_pkg SHALL hold the FSM state typedef (IDLE, MEASURE, STALLED) and the synchronizer depth constant (2).
REQ-029 Synchronizer plus edge detection SHALL be a sub-module sync_edge_detect (ports clock, reset, async_in, rise, fall).

Verification
REQ-030 The bench SHALL cover: clock_in toggles every 4 clock cycles -> second and later measure_valid show period=8, high_time=4 (DUTY_EN).
REQ-031 The bench SHALL cover: clock_in high 3 / low 7 cycles -> period=10, high_time=3 with DUTY_EN; high_time=0 without.
REQ-032 The bench SHALL cover: TIMEOUT=100, clock_in held low after edges -> stalled=1 within 101 cycles of the last rise; period holds its last value; next rise clears stalled with no valid; the following rise gives a valid period.
REQ-033 The bench SHALL cover: CNT_WIDTH=4, clock_in period 40, TIMEOUT=1000 -> period=15 (saturated).
REQ-034 The bench SHALL cover: reset pulsed 5 cycles after a rise -> all outputs 0; the next rise gives no measure_valid; the one after gives the correct period.
REQ-035 The bench SHALL cover: rise coinciding with the timeout cycle -> stalled stays 0 and measure_valid fires.
